pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
- REQ-001 SHALL have parameter LOAD_LAT, default 1, data-memory load latency in cycles (1..7).
- REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
- REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
- REQ-004 SHALL have port rs1_if_id, rs2_if_id  input  `REG_W  source register indices of the instruction in ID.
- REQ-005 SHALL have port rs1_used, rs2_used  input  1  the ID instruction actually reads rs1 or rs2.
- REQ-006 SHALL have port rd_id_ex  input  `REG_W  destination of the instruction in EX.
- REQ-007 SHALL have port MemRead_id_ex  input  1  the EX instruction is a load.
- REQ-008 SHALL have port redirect_ex  input  1  taken branch or jump resolved in EX.
- REQ-009 SHALL have ports mdu_start, mdu_done  input  1  multi-cycle mul/div op in EX starts, result ready.
- REQ-010 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en  output  1  stage register write enables.
- REQ-011 SHALL have ports id_ex_bubble, if_id_flush  output  1  insert NOP into ID/EX, clear IF/ID.
- REQ-012 SHALL have port state  output  2  current FSM state.
- REQ-013 SHALL have port stall_cycles  output  32  performance counter (see Configuration).

Function
- REQ-014 SHALL implement FSM RUN=00, LU_WAIT=01, MDU_BUSY=10, REDIRECT=11.
- REQ-015 SHALL define hazard = MemRead_id_ex && rd_id_ex!=0 && ((rs1_used && rs1_if_id==rd_id_ex) || (rs2_used && rs2_if_id==rd_id_ex)).
- REQ-016 SHALL, in RUN, apply priority redirect_ex > mdu_start > hazard, all decided combinationally in the same cycle.
- REQ-017 SHALL, in RUN with redirect_ex: if_id_flush=1, id_ex_bubble=1, all enables 1; next state REDIRECT.
- REQ-018 SHALL, in REDIRECT: all enables 1, no flush or bubble; next state RUN; hazard/mdu_start are evaluated as in RUN.
- REQ-019 SHALL, in RUN with mdu_start && !mdu_done: all four enables 0; next state MDU_BUSY; mdu_start && mdu_done causes no stall.
- REQ-020 SHALL, in MDU_BUSY: all enables 0 while !mdu_done; on mdu_done all enables 1 in that cycle; next state RUN; redirect_ex ignored.
- REQ-021 SHALL, in RUN with hazard: pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=1.
- REQ-022 SHALL, when LOAD_LAT>1, load a 3-bit down-counter with LOAD_LAT-1 on hazard and enter LU_WAIT; with LOAD_LAT=1, remain in RUN.
- REQ-023 SHALL, in LU_WAIT: all four enables 0, no bubble; decrement counter each cycle; leave for RUN in the cycle the counter reads 1 (total stall = LOAD_LAT cycles).
- REQ-024 SHALL ignore redirect_ex, mdu_start and hazard in LU_WAIT.
- REQ-025 SHALL drive enables 1 and flush/bubble 0 in RUN with no event.

Reset
- REQ-026 SHALL, while rst=1, force state=RUN, counter=0, stall_cycles=0, enables=1, id_ex_bubble=0, if_id_flush=0.
- REQ-027 SHALL abort any LU_WAIT or MDU_BUSY on rst assertion mid-operation, with no residual stall after deassertion.

Configuration
- REQ-028 SHALL, with HAZARD_PERF_CNT_EN defined, increment stall_cycles (wrapping at 2^32) every cycle pc_en=0.
- REQ-029 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cycles to 0 and instantiate no counter flops.

Verification
- REQ-030 SHALL cover: LOAD_LAT=1, load to x5 in EX, ID reads rs1=x5 -> one cycle pc_en=0, id_ex_bubble=1, then RUN.
- REQ-031 SHALL cover: LOAD_LAT=3, same hazard -> 1 bubble cycle plus 2 LU_WAIT cycles with all enables 0; stall_cycles=3 when HAZARD_PERF_CNT_EN is defined.
- REQ-032 SHALL cover: load to x0 with rs1=x0, and load to x5 with rs1=x5 but rs1_used=0 -> no stall.
- REQ-033 SHALL cover: redirect_ex and hazard in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_en=1, next state REDIRECT.
- REQ-034 SHALL cover: mdu_start, mdu_done after 4 cycles -> enables 0 for 4 cycles, 1 on the done cycle; start+done together -> no stall.
- REQ-035 SHALL cover: rst asserted in cycle 2 of MDU_BUSY -> state=RUN and enables=1 immediately and after deassertion.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller for a 5-stage core.
// Handles load-use hazards (with a configurable load latency),
// multi-cycle mul/div ops in EX, and taken-branch redirects.
// Macros:
//   REG_W               register index width (defaults to 5)
//   HAZARD_PERF_CNT_EN  when defined, stall_cycles counts cycles with pc_en=0;
//                       otherwise stall_cycles is tied to 0 and has no flops.
//
// state    | meaning
// RUN      | normal flow, events decided combinationally
// LU_WAIT  | extra load-latency stall cycles after the bubble
// MDU_BUSY | mul/div in EX, whole pipe frozen until mdu_done
// REDIRECT | cycle after a taken branch/jump flush

`ifndef REG_W
`define REG_W 5
`endif

module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`REG_W-1:0] rs1_if_id,
  input  logic [`REG_W-1:0] rs2_if_id,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [`REG_W-1:0] rd_id_ex,
  input  logic              MemRead_id_ex,
  input  logic              redirect_ex,
  input  logic              mdu_start,
  input  logic              mdu_done,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [1:0]        state,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_WAIT  = 2'b01,
    MDU_BUSY = 2'b10,
    REDIRECT = 2'b11
  } state_e;

  // Counter start value: the bubble cycle itself is the first stall cycle.
  localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;

  assign hazard = MemRead_id_ex && (rd_id_ex != '0) &&
                  ((rs1_used && (rs1_if_id == rd_id_ex)) ||
                   (rs2_used && (rs2_if_id == rd_id_ex)));

  assign state = state_q;

  // State and load-latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stage-control decode; reset forces the idle outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;

    case (state_q)
      RUN, REDIRECT: begin
        state_d = RUN;
        // In REDIRECT the EX slot holds a flushed bubble, so no redirect there.
        if ((state_q == RUN) && redirect_ex) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = REDIRECT;
        end else if (mdu_start && !mdu_done) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          state_d   = MDU_BUSY;
        end else if (mdu_start) begin
          // Single-cycle completion: no stall.
          state_d = RUN;
        end else if (hazard) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_d   = LU_INIT;
            state_d = LU_WAIT;
          end
        end
      end

      LU_WAIT: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
        end
      end

      MDU_BUSY: begin
        if (!mdu_done) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
        end else begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      state_d      = RUN;
      cnt_d        = 3'd0;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;

  // Free-running stall counter, wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (!pc_en) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3)
// share the same stimulus; expectations are queued by the stimulus process
// and checked by a separate monitor on the falling edge.

`ifndef REG_W
`define REG_W 5
`endif

module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  logic [`REG_W-1:0] rs1_if_id, rs2_if_id, rd_id_ex;
  logic rs1_used, rs2_used, MemRead_id_ex, redirect_ex, mdu_start, mdu_done;

  logic pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, bub1, flush1;
  logic [1:0] st1;
  logic [31:0] stall1;
  logic pc_en3, if_id_en3, id_ex_en3, ex_mem_en3, bub3, flush3;
  logic [1:0] st3;
  logic [31:0] stall3;

  pipe_hazard_ctrl #(.LOAD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .rs1_if_id(rs1_if_id), .rs2_if_id(rs2_if_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_id_ex(rd_id_ex), .MemRead_id_ex(MemRead_id_ex),
    .redirect_ex(redirect_ex), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_en(pc_en1), .if_id_en(if_id_en1), .id_ex_en(id_ex_en1), .ex_mem_en(ex_mem_en1),
    .id_ex_bubble(bub1), .if_id_flush(flush1), .state(st1), .stall_cycles(stall1)
  );

  pipe_hazard_ctrl #(.LOAD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .rs1_if_id(rs1_if_id), .rs2_if_id(rs2_if_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_id_ex(rd_id_ex), .MemRead_id_ex(MemRead_id_ex),
    .redirect_ex(redirect_ex), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_en(pc_en3), .if_id_en(if_id_en3), .id_ex_en(id_ex_en3), .ex_mem_en(ex_mem_en3),
    .id_ex_bubble(bub3), .if_id_flush(flush3), .state(st3), .stall_cycles(stall3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word: {state[1:0], pc_en, if_id_en, id_ex_en, ex_mem_en, bubble, flush}
  localparam logic [7:0] IDLE  = {2'b00, 4'b1111, 2'b00};
  localparam logic [7:0] HZ_R  = {2'b00, 4'b0011, 2'b10};
  localparam logic [7:0] HZ_RD = {2'b11, 4'b0011, 2'b10};
  localparam logic [7:0] LW0   = {2'b01, 4'b0000, 2'b00};
  localparam logic [7:0] RED_R = {2'b00, 4'b1111, 2'b11};
  localparam logic [7:0] RD_I  = {2'b11, 4'b1111, 2'b00};
  localparam logic [7:0] MD_R  = {2'b00, 4'b0000, 2'b00};
  localparam logic [7:0] MB0   = {2'b10, 4'b0000, 2'b00};
  localparam logic [7:0] MB1   = {2'b10, 4'b1111, 2'b00};

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  e1;
    logic [7:0]  e3;
    logic [31:0] s1;
    logic [31:0] s3;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int row_n = 0;
  int acc1 = 0;
  int acc3 = 0;

  // Apply one cycle of inputs (at posedge+1) and queue its expected outputs.
  task automatic cyc(input logic r,
                     input logic [`REG_W-1:0] a1, input logic [`REG_W-1:0] a2,
                     input logic u1, input logic u2,
                     input logic [`REG_W-1:0] d, input logic mr,
                     input logic rdr, input logic ms, input logic md,
                     input logic [7:0] e1, input logic [7:0] e3);
    exp_t x;
    rst = r; rs1_if_id = a1; rs2_if_id = a2; rs1_used = u1; rs2_used = u2;
    rd_id_ex = d; MemRead_id_ex = mr; redirect_ex = rdr; mdu_start = ms; mdu_done = md;
    if (r) begin
      acc1 = 0;
      acc3 = 0;
    end
    x.row = 8'(row_n);
    x.e1 = e1;
    x.e3 = e3;
`ifdef HAZARD_PERF_CNT_EN
    x.s1 = 32'(acc1);
    x.s3 = 32'(acc3);
`else
    x.s1 = 32'd0;
    x.s3 = 32'd0;
`endif
    exp_q.push_back(x);
    if (!e1[5]) acc1++;
    if (!e3[5]) acc3++;
    row_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] e1, input logic [7:0] e3);
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, e1, e3);
  endtask

  // Monitor: every falling edge with a pending expectation is checked.
  always @(negedge clk) begin
    exp_t x;
    logic [7:0] g1, g3;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      g1 = {st1, pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, bub1, flush1};
      g3 = {st3, pc_en3, if_id_en3, id_ex_en3, ex_mem_en3, bub3, flush3};
      total++;
      if (g1 !== x.e1) begin
        bad++;
        $display("FAIL ctl_lat1 row=%0d got=%b want=%b", x.row, g1, x.e1);
      end
      total++;
      if (g3 !== x.e3) begin
        bad++;
        $display("FAIL ctl_lat3 row=%0d got=%b want=%b", x.row, g3, x.e3);
      end
      total++;
      if (stall1 !== x.s1) begin
        bad++;
        $display("FAIL stall_lat1 row=%0d got=%0d want=%0d", x.row, stall1, x.s1);
      end
      total++;
      if (stall3 !== x.s3) begin
        bad++;
        $display("FAIL stall_lat3 row=%0d got=%0d want=%0d", x.row, stall3, x.s3);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rs1_if_id = '0; rs2_if_id = '0; rd_id_ex = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; MemRead_id_ex = 1'b0;
    redirect_ex = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
    @(posedge clk);
    #1;
    // reset forces idle outputs even with hazard / redirect / mdu inputs active
    cyc(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, IDLE, IDLE);               // 0
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, IDLE, IDLE);               // 1
    idle(IDLE, IDLE);                                            // 2
    // no-stall cases: x0 destination, rs1 not used
    cyc(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, IDLE, IDLE);               // 3
    cyc(0, 5, 5, 0, 0, 5, 1, 0, 0, 0, IDLE, IDLE);               // 4
    // load-use on rs1=x5
    cyc(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, HZ_R, HZ_R);               // 5
    idle(IDLE, LW0);                                             // 6
    idle(IDLE, LW0);                                             // 7
    idle(IDLE, IDLE);                                            // 8
    // load-use on rs2; LU_WAIT ignores redirect and mdu_start
    cyc(0, 7, 7, 0, 1, 7, 1, 0, 0, 0, HZ_R, HZ_R);               // 9
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, RED_R, LW0);               // 10
    idle(RD_I, LW0);                                             // 11
    idle(IDLE, IDLE);                                            // 12
    // redirect and hazard together, then hazard evaluated in REDIRECT
    cyc(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, RED_R, RED_R);             // 13
    cyc(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, HZ_RD, HZ_RD);             // 14
    idle(IDLE, LW0);                                             // 15
    idle(IDLE, LW0);                                             // 16
    idle(IDLE, IDLE);                                            // 17
    // mdu_start beats hazard; done after 4 cycles; redirect ignored while busy
    cyc(0, 5, 0, 1, 0, 5, 1, 0, 1, 0, MD_R, MD_R);               // 18
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MB0, MB0);                 // 19
    idle(MB0, MB0);                                              // 20
    idle(MB0, MB0);                                              // 21
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MB1, MB1);                 // 22
    idle(IDLE, IDLE);                                            // 23
    // start and done together: no stall
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE, IDLE);               // 24
    idle(IDLE, IDLE);                                            // 25
    // reset in cycle 2 of MDU_BUSY
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MD_R, MD_R);               // 26
    idle(MB0, MB0);                                              // 27
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, IDLE);               // 28
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, IDLE, IDLE);               // 29
    idle(IDLE, IDLE);                                            // 30
    idle(IDLE, IDLE);                                            // 31

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
